rom_sequencer: RTL and testbench

Microcode sequencer that drives a 64x20 synchronous block-ROM (1-cycle read latency, enable-gated) and executes the words it returns. Generates rom_en/rom_addr, decodes each 20-bit word, and emits 12-bit payloads downstream over a valid/ready handshake. Sits directly upstream of the ROM (address/enable source) and also consumes its data output.

---
 rtl/rom_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_rom_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_sequencer.sv
// Microcode sequencer: fetches 20-bit words from a 1-cycle-latency ROM, executes them, and emits 12-bit payloads.
// Optional ROM_SEQ_WATCHDOG_EN macro adds an EXEC step limit of MAX_STEPS per run.
module rom_sequencer #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 20,
  parameter int MAX_STEPS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [11:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WAIT  = 3'd3,
    S_EMIT  = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  localparam logic [3:0] OP_EMIT = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'h2;
  localparam logic [3:0] OP_WAIT = 4'h4;
  localparam logic [3:0] OP_LDC  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        loop_cnt_q, loop_cnt_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic [11:0]       out_data_q, out_data_d;
  logic              err_q, err_d;
  logic              wd_trip;

  logic [3:0]        rsvd, op, sub;
  logic [7:0]        imm;
  logic [ADDR_W-1:0] target, pc_inc;
  logic [7:0]        loop_dec;

  assign rsvd     = rom_data[19:16];
  assign op       = rom_data[15:12];
  assign sub      = rom_data[11:8];
  assign imm      = rom_data[7:0];
  assign target   = rom_data[ADDR_W-1:0];
  assign pc_inc   = pc_q + 1'b1;
  assign loop_dec = loop_cnt_q - 8'd1;

  function automatic logic word_legal(input logic [3:0] r, input logic [3:0] o, input logic [3:0] s);
    logic ok;
    ok = 1'b0;
    if (r == 4'h0) begin
      case (o)
        OP_EMIT, OP_WAIT, OP_LDC, OP_HALT: ok = 1'b1;
        OP_JMP:                            ok = (s == 4'h0) || (s == 4'h1);
        default:                           ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

`ifdef ROM_SEQ_WATCHDOG_EN
  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  logic [STEP_W-1:0] step_q, step_d;

  assign wd_trip = (state_q == S_EXEC) && (step_q == STEP_W'(MAX_STEPS));

  always_comb begin
    step_d = step_q;
    if (state_q == S_IDLE && start)
      step_d = '0;
    else if (state_q == S_EXEC && !wd_trip)
      step_d = step_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) step_q <= '0;
    else     step_q <= step_d;
  end
`else
  assign wd_trip = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    loop_cnt_d = loop_cnt_q;
    wait_cnt_d = wait_cnt_q;
    out_data_d = out_data_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = '0;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        if (wd_trip || !word_legal(rsvd, op, sub)) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          case (op)
            OP_EMIT: begin
              out_data_d = rom_data[11:0];
              state_d    = S_EMIT;
            end
            OP_JMP: begin
              state_d = S_FETCH;
              if (sub == 4'h0) begin
                pc_d = target;
              end else begin
                // DJNZ: decrement wraps 0 -> 255, which still branches
                loop_cnt_d = loop_dec;
                pc_d       = (loop_dec != 8'd0) ? target : pc_inc;
              end
            end
            OP_WAIT: begin
              if (imm == 8'd0) begin
                pc_d    = pc_inc;
                state_d = S_FETCH;
              end else begin
                wait_cnt_d = imm - 8'd1;
                state_d    = S_WAIT;
              end
            end
            OP_LDC: begin
              loop_cnt_d = imm;
              pc_d       = pc_inc;
              state_d    = S_FETCH;
            end
            default: state_d = S_HALT;
          endcase
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 8'd0) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q - 8'd1;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      loop_cnt_q <= '0;
      wait_cnt_q <= '0;
      out_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      loop_cnt_q <= loop_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      out_data_q <= out_data_d;
      err_q      <= err_d;
    end
  end

  assign rom_en    = (state_q == S_FETCH);
  assign rom_addr  = pc_q;
  assign out_data  = out_data_q;
  assign out_valid = (state_q == S_EMIT);
  assign busy      = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                     (state_q == S_WAIT)  || (state_q == S_EMIT);
  assign done      = (state_q == S_HALT);
  assign err       = err_q;

endmodule

// File: tb/tb_rom_sequencer.sv
// Directed bench for rom_sequencer with a behavioural 64x20 ROM (1-cycle latency, enable-gated).
module tb_rom_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic        rom_en;
  logic [5:0]  rom_addr;
  logic [19:0] rom_data = 20'h0;
  logic [11:0] out_data;
  logic        out_valid, busy, done, err;

  logic [19:0] rom [0:63];
  int          cyc = 0;
  int          emit_cnt = 0;
  logic [11:0] last_emit = 12'h0;
  int          checks = 0;
  int          errors = 0;

  rom_sequencer #(.ADDR_W(6), .DATA_W(20), .MAX_STEPS(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rom_en) rom_data <= rom[rom_addr];
    if (out_valid && out_ready) begin
      emit_cnt  <= emit_cnt + 1;
      last_emit <= out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 20'h0F000;
  endtask

  task automatic do_start(output int t0);
    t0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int t0, input int limit, output int dt);
    int n;
    dt = -1;
    n = 0;
    while (dt < 0 && n < limit) begin
      if (done) dt = cyc - t0;
      else begin
        tick();
        n++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({rom_en, rom_addr, out_data, out_valid, busy, done, err} !== 23'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", {rom_en, rom_addr, out_data, out_valid, busy, done, err});
    end
  endtask

  task automatic test_halt();
    int t0, dt;
    clear_rom();
    do_start(t0);
    checks++;
    if (rom_en !== 1'b1 || rom_addr !== 6'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL halt_fetch en=%b addr=%0d busy=%b exp 1 0 1", rom_en, rom_addr, busy);
    end
    wait_done(t0, 20, dt);
    checks++;
    if (dt !== 3) begin errors++; $display("FAIL halt_done_cycle got %0d exp 3", dt); end
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL halt_flags busy=%b err=%b exp 0 0", busy, err);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL halt_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_wrap_djnz();
    int t0, dt, e0;
    bit saw63;
    rst = 1'b1; tick(); rst = 1'b0;
    clear_rom();
    rom[0]  = 20'h02102;
    rom[1]  = 20'h0F000;
    rom[2]  = 20'h08001;
    rom[3]  = 20'h0203F;
    rom[63] = 20'h00066;
    out_ready = 1'b1;
    e0 = emit_cnt;
    saw63 = 1'b0;
    do_start(t0);
    dt = -1;
    for (int i = 0; i < 40 && dt < 0; i++) begin
      if (rom_en && rom_addr == 6'd63) saw63 = 1'b1;
      if (done) dt = cyc - t0;
      else tick();
    end
    checks++;
    if (dt !== 14) begin errors++; $display("FAIL wrap_done_cycle got %0d exp 14", dt); end
    checks++;
    if (saw63 !== 1'b1) begin errors++; $display("FAIL wrap_fetch63 got %b exp 1", saw63); end
    checks++;
    if (emit_cnt - e0 !== 1 || last_emit !== 12'h066) begin
      errors++; $display("FAIL wrap_emit count=%0d data=%h exp 1 066", emit_cnt - e0, last_emit);
    end
    tick();
  endtask

  task automatic test_emit_stall();
    int t0, dt, e0, bad;
    clear_rom();
    rom[0] = 20'h00ABC;
    rom[1] = 20'h0F000;
    out_ready = 1'b0;
    e0 = emit_cnt;
    do_start(t0);
    tick(); tick();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_data !== 12'hABC) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL stall_hold bad_cycles=%0d exp 0", bad); end
    checks++;
    if (out_valid !== 1'b1 || cyc - t0 !== 8) begin
      errors++; $display("FAIL stall_still_valid valid=%b cyc=%0d exp 1 8", out_valid, cyc - t0);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || rom_en !== 1'b1 || rom_addr !== 6'd1) begin
      errors++; $display("FAIL stall_accept valid=%b en=%b addr=%0d exp 0 1 1", out_valid, rom_en, rom_addr);
    end
    wait_done(t0, 20, dt);
    checks++;
    if (dt !== 11) begin errors++; $display("FAIL stall_done_cycle got %0d exp 11", dt); end
    checks++;
    if (emit_cnt - e0 !== 1 || last_emit !== 12'hABC) begin
      errors++; $display("FAIL stall_transfer count=%0d data=%h exp 1 abc", emit_cnt - e0, last_emit);
    end
    tick();
  endtask

  task automatic test_loop();
    int t0, dt, e0;
    clear_rom();
    rom[0] = 20'h08003;
    rom[1] = 20'h00011;
    rom[2] = 20'h02101;
    rom[3] = 20'h0F000;
    out_ready = 1'b1;
    e0 = emit_cnt;
    do_start(t0);
    wait_done(t0, 60, dt);
    checks++;
    if (dt !== 20) begin errors++; $display("FAIL loop_done_cycle got %0d exp 20", dt); end
    checks++;
    if (emit_cnt - e0 !== 3 || last_emit !== 12'h011) begin
      errors++; $display("FAIL loop_emits count=%0d data=%h exp 3 011", emit_cnt - e0, last_emit);
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL loop_err got %b exp 0", err); end
    tick();
  endtask

  task automatic test_wait();
    int t0, dt, tf;
    clear_rom();
    rom[0] = 20'h04005;
    do_start(t0);
    tf = -1;
    for (int i = 0; i < 30 && tf < 0; i++) begin
      if (rom_en && rom_addr == 6'd1) tf = cyc - t0;
      else tick();
    end
    checks++;
    if (tf !== 8) begin errors++; $display("FAIL wait5_fetch_cycle got %0d exp 8", tf); end
    wait_done(t0, 20, dt);
    checks++;
    if (dt !== 10) begin errors++; $display("FAIL wait5_done_cycle got %0d exp 10", dt); end
    tick();
    rom[0] = 20'h04000;
    do_start(t0);
    wait_done(t0, 20, dt);
    checks++;
    if (dt !== 5) begin errors++; $display("FAIL wait0_done_cycle got %0d exp 5", dt); end
    tick();
  endtask

  task automatic test_errors();
    int t0, dt, e0;
    logic [19:0] bad_words [0:2];
    bad_words[0] = 20'h10000;
    bad_words[1] = 20'h03000;
    bad_words[2] = 20'h02200;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      clear_rom();
      rom[0] = bad_words[k];
      rom[1] = 20'h00123;
      e0 = emit_cnt;
      do_start(t0);
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL illegal%0d_err_clear got %b exp 0", k, err); end
      wait_done(t0, 20, dt);
      checks++;
      if (dt !== 3 || err !== 1'b1) begin
        errors++; $display("FAIL illegal%0d_halt cycle=%0d err=%b exp 3 1", k, dt, err);
      end
      tick(); tick();
      checks++;
      if (err !== 1'b1 || emit_cnt !== e0) begin
        errors++; $display("FAIL illegal%0d_sticky err=%b emits=%0d exp 1 0", k, err, emit_cnt - e0);
      end
    end
    clear_rom();
    do_start(t0);
    wait_done(t0, 20, dt);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_cleared_by_start got %b exp 0", err); end
    tick();
  endtask

  task automatic test_runaway();
    int t0;
    clear_rom();
    rom[0] = 20'h02000;
    do_start(t0);
`ifdef ROM_SEQ_WATCHDOG_EN
    begin
      int dt;
      wait_done(t0, 100, dt);
      checks++;
      if (dt !== 35 || err !== 1'b1) begin
        errors++; $display("FAIL watchdog_trip cycle=%0d err=%b exp 35 1", dt, err);
      end
    end
`else
    repeat (100) tick();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL runaway_busy busy=%b done=%b err=%b exp 1 0 0", busy, done, err);
    end
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({rom_en, rom_addr, out_data, out_valid, busy, done, err} !== 23'h0) begin
      errors++;
      $display("FAIL runaway_reset got %h exp 0", {rom_en, rom_addr, out_data, out_valid, busy, done, err});
    end
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_halt();
    test_wrap_djnz();
    test_emit_stall();
    test_loop();
    test_wait();
    test_errors();
    test_runaway();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
